pipe_stage_chain: RTL and testbench

// Parametrised chain of STAGES pipeline registers carrying {pc, exception code, payload} with valid/ready

---
 rtl/pipe_stage_chain.sv | 156 +++++++++++++++
 tb/tb_pipe_stage_chain.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers carrying {pc, exception code, payload} with valid/ready
// handshake, per-stage hold and flush, and precise-exception retirement with a fetch redirect window.
module pipe_stage_chain #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STAGES    = 4,
  parameter int unsigned EXC_W     = 8,
  parameter int unsigned REDIR_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_pc,
  input  logic [EXC_W-1:0]              in_exc,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [STAGES-1:0]             hold,
  input  logic [STAGES-1:0]             flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_pc,
  output logic [EXC_W-1:0]              out_exc,
  output logic [WIDTH-1:0]              out_data,
  output logic                          exc_taken,
  output logic [31:0]                   exc_pc,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);
  localparam int unsigned CNT_W = $clog2(REDIR_CYC + 1);

  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [EXC_W-1:0] exc;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  entry_t            stage_q [STAGES];
  entry_t            stage_d [STAGES];
  entry_t            up_c    [STAGES];
  logic [STAGES:0]   ready_c;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              exc_taken_c;
  logic              in_ready_c;

  // Backpressure ripples from the tail toward the head; a held stage never accepts.
  always_comb begin
    ready_c         = '0;
    ready_c[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      ready_c[k] = ~hold[k] & (~stage_q[k].valid | ready_c[k+1]);
    end
  end

  assign exc_taken_c = stage_q[STAGES-1].valid & out_ready & (|stage_q[STAGES-1].exc);
  assign in_ready_c  = ~rst & ready_c[0] & (state_q == ST_RUN) & ~exc_taken_c;

  // Candidate entry presented to each stage; a held or empty upstream stage yields a zeroed bubble.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      up_c[k] = '0;
    end
    if (in_valid && in_ready_c) begin
      up_c[0].valid = 1'b1;
      up_c[0].pc    = in_pc;
      up_c[0].exc   = in_exc;
      up_c[0].data  = in_data;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (stage_q[k-1].valid && !hold[k-1]) begin
        up_c[k] = stage_q[k-1];
      end
    end
  end

  // Per-stage update: retiring exception and flush clear, hold keeps, otherwise load when ready.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      stage_d[k] = stage_q[k];
      if (exc_taken_c || flush[k]) begin
        stage_d[k] = '0;
      end else if (hold[k]) begin
        stage_d[k] = stage_q[k];
      end else if (ready_c[k]) begin
        stage_d[k] = up_c[k];
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      occ_d = occ_d + OCC_W'(stage_d[k].valid);
    end
  end

  // Redirect window: fetch stays blocked while the counter drains after a trap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (exc_taken_c) begin
          state_d = ST_REDIR;
          cnt_d   = CNT_W'(REDIR_CYC - 1);
        end
      end
      ST_REDIR: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_q[k] <= '0;
      end
      state_q <= ST_RUN;
      cnt_q   <= '0;
      occ_q   <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_q[k] <= stage_d[k];
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = stage_q[STAGES-1].valid;
  assign out_pc    = stage_q[STAGES-1].pc;
  assign out_exc   = stage_q[STAGES-1].exc;
  assign out_data  = stage_q[STAGES-1].data;
  assign exc_taken = exc_taken_c;
  assign exc_pc    = stage_q[STAGES-1].pc;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: streaming, hold bubbles, backpressure, flush, exception
// retirement with redirect window, and reset during operation.
module tb_pipe_stage_chain;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned STAGES    = 4;
  localparam int unsigned EXC_W     = 8;
  localparam int unsigned REDIR_CYC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [EXC_W-1:0]  in_exc;
  logic [WIDTH-1:0]  in_data;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] flush;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [EXC_W-1:0]  out_exc;
  logic [WIDTH-1:0]  out_data;
  logic              exc_taken;
  logic [31:0]       exc_pc;
  logic [2:0]        occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_chain #(
    .WIDTH(WIDTH), .STAGES(STAGES), .EXC_W(EXC_W), .REDIR_CYC(REDIR_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_exc(in_exc), .in_data(in_data),
    .hold(hold), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_exc(out_exc),
    .out_data(out_data), .exc_taken(exc_taken), .exc_pc(exc_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [7:0] exc,
                       input logic [3:0] h, input logic [3:0] f, input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_exc    = exc;
    in_data   = v ? {16'hD000, pc[15:0]} : 32'h0;
    hold      = h;
    flush     = f;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 8'h0, 4'b0000, 4'b0000, 1'b0);
    chk("rst_in_ready", in_ready, 0);
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_exc_taken", exc_taken, 0);
    rst = 1'b0;
    #1;
    chk("run_in_ready", in_ready, 1);

    // Back-to-back stream: first pc reaches the tail four edges after acceptance.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 8'h0, 4'b0000, 4'b0000, 1'b1);
      tick();
      chk("stream_valid", out_valid, 64'(i >= 3));
      chk("stream_occ", occupancy, (i >= 3) ? 64'd4 : 64'(i + 1));
      if (i >= 3) chk("stream_pc", out_pc, 32'h100 + 32'(4 * (i - 3)));
      if (i == 3) chk("stream_data", out_data, 32'hD000_0100);
    end

    // hold[1] for two cycles inserts two bubbles ahead of stage 2.
    drive(1'b1, 32'h120, 8'h0, 4'b0010, 4'b0000, 1'b1);
    chk("hold_in_ready", in_ready, 0);
    tick();
    chk("hold1_pc", out_pc, 32'h114);
    chk("hold1_occ", occupancy, 3);
    drive(1'b1, 32'h120, 8'h0, 4'b0010, 4'b0000, 1'b1);
    tick();
    chk("hold2_valid", out_valid, 0);
    chk("hold2_occ", occupancy, 2);
    drive(1'b1, 32'h120, 8'h0, 4'b0000, 4'b0000, 1'b1);
    chk("hold_rel_in_ready", in_ready, 1);
    tick();
    chk("hold3_valid", out_valid, 0);
    chk("hold3_occ", occupancy, 3);
    drive(1'b1, 32'h124, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    chk("hold4_pc", out_pc, 32'h118);
    chk("hold4_occ", occupancy, 4);
    drive(1'b1, 32'h128, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    chk("hold5_pc", out_pc, 32'h11C);
    drive(1'b1, 32'h12C, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    chk("hold6_pc", out_pc, 32'h120);

    // Consumer stalls three cycles on a full chain; order must be preserved afterwards.
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 32'h130, 8'h0, 4'b0000, 4'b0000, 1'b0);
      chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_pc", out_pc, 32'h120);
      chk("bp_occ", occupancy, 4);
    end
    drive(1'b1, 32'h130, 8'h0, 4'b0000, 4'b0000, 1'b1);
    chk("bp_rel_in_ready", in_ready, 1);
    tick();
    chk("bp_rel1_pc", out_pc, 32'h124);
    drive(1'b1, 32'h134, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    chk("bp_rel2_pc", out_pc, 32'h128);
    drive(1'b1, 32'h138, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    chk("bp_rel3_pc", out_pc, 32'h12C);

    // Flush stages 0 and 1 while stalled: 0x134/0x138 vanish, 0x12C/0x130 retire.
    drive(1'b0, 32'h0, 8'h0, 4'b0000, 4'b0011, 1'b0);
    tick();
    chk("flush_occ", occupancy, 2);
    chk("flush_pc", out_pc, 32'h12C);
    drive(1'b0, 32'h0, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    chk("flush_next_pc", out_pc, 32'h130);
    chk("flush_next_occ", occupancy, 1);
    tick();
    chk("flush_drain_valid", out_valid, 0);
    chk("flush_drain_occ", occupancy, 0);

    // Excepting entry followed by normal traffic.
    drive(1'b1, 32'hBFC0_0004, 8'h80, 4'b0000, 4'b0000, 1'b1);
    tick();
    drive(1'b1, 32'h200, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    drive(1'b1, 32'h204, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    drive(1'b1, 32'h208, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    chk("exc_pre_occ", occupancy, 4);
    chk("exc_pre_pc", out_pc, 32'hBFC0_0004);
    drive(1'b1, 32'h20C, 8'h0, 4'b0000, 4'b0000, 1'b1);
    chk("exc_taken", exc_taken, 1);
    chk("exc_pc", exc_pc, 32'hBFC0_0004);
    chk("exc_code", out_exc, 8'h80);
    chk("exc_in_ready", in_ready, 0);
    tick();
    chk("redir1_occ", occupancy, 0);
    chk("redir1_valid", out_valid, 0);
    chk("redir1_in_ready", in_ready, 0);
    chk("redir1_exc_taken", exc_taken, 0);
    tick();
    chk("redir2_in_ready", in_ready, 0);
    chk("redir2_occ", occupancy, 0);
    tick();
    chk("redir_done_in_ready", in_ready, 1);
    tick();
    drive(1'b1, 32'h210, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    chk("refill_occ", occupancy, 2);

    // Reset with a partly filled chain.
    rst = 1'b1;
    drive(1'b1, 32'h214, 8'h0, 4'b0000, 4'b0000, 1'b1);
    chk("rst_mid_in_ready", in_ready, 0);
    tick();
    chk("rst_mid_occ", occupancy, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_pc", out_pc, 0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 8'h0, 4'b0000, 4'b0000, 1'b1);
    chk("rst_mid_rel_in_ready", in_ready, 1);

    // Trap, then reset inside the redirect window returns straight to RUN.
    drive(1'b1, 32'h300, 8'h04, 4'b0000, 4'b0000, 1'b1);
    tick();
    drive(1'b0, 32'h0, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    tick();
    tick();
    chk("exc2_taken", exc_taken, 1);
    chk("exc2_pc", exc_pc, 32'h300);
    tick();
    chk("exc2_redir_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    tick();
    chk("rst_redir_occ", occupancy, 0);
    chk("rst_redir_valid", out_valid, 0);
    chk("rst_redir_exc", out_exc, 0);
    rst = 1'b0;
    #1;
    chk("rst_redir_in_ready", in_ready, 1);

    // Single entry after recovery: latency of four edges.
    drive(1'b1, 32'h400, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    drive(1'b0, 32'h0, 8'h0, 4'b0000, 4'b0000, 1'b1);
    tick();
    tick();
    chk("lat_not_yet", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_pc", out_pc, 32'h400);
    chk("lat_occ", occupancy, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
